// File: rtl/motion_frame_collector_if.sv
// Pixel-flag input stream and frame-summary result port of motion_frame_collector.
// The master side drives pixels and accepts results; the slave side is the collector.
interface motion_frame_collector_if #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 19
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic             in_valid;
    logic             in_sof;
    logic             in_motion;
    logic [CNT_W-1:0] alarm_threshold;
    logic             result_valid;
    logic             result_ready;
    logic [CNT_W-1:0] motion_count;
    logic             alarm;
    logic             overrun;
    logic             frame_abort;
    logic [XW-1:0]    bbox_x_min;
    logic [XW-1:0]    bbox_x_max;
    logic [YW-1:0]    bbox_y_min;
    logic [YW-1:0]    bbox_y_max;
    logic             bbox_valid;

    modport master (
        output in_valid, in_sof, in_motion, alarm_threshold, result_ready,
        input  result_valid, motion_count, alarm, overrun, frame_abort,
        input  bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_valid
    );

    modport slave (
        input  in_valid, in_sof, in_motion, alarm_threshold, result_ready,
        output result_valid, motion_count, alarm, overrun, frame_abort,
        output bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_valid
    );
endinterface

// File: rtl/motion_frame_collector.sv
// Reduces a raster stream of motion flags to a per-frame summary (count, alarm, bbox).
// Bounding-box tracking is built only when MOTION_FRAME_BBOX_EN is defined.
module motion_frame_collector #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 19
) (
    input logic                   clk,
    input logic                   rst,
    motion_frame_collector_if.slave bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic {ST_IDLE, ST_ACCUM} state_e;

    state_e           state_q, state_d;
    logic [XW-1:0]    x_q, x_d, px_x;
    logic [YW-1:0]    y_q, y_d, px_y;
    logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt, px_cnt;
    logic             px_take, frame_done;

    logic             res_valid_q, res_valid_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic             res_alarm_q, res_alarm_d;
    logic             overrun_q, overrun_d;
    logic             abort_q, abort_d;

    // An in_sof pixel always starts a fresh frame at (0,0), in either state.
    always_comb begin
        px_take  = bus.in_valid && (state_q == ST_ACCUM || bus.in_sof);
        px_x     = bus.in_sof ? '0 : x_q;
        px_y     = bus.in_sof ? '0 : y_q;
        base_cnt = bus.in_sof ? '0 : cnt_q;
        px_cnt   = base_cnt;
        if (bus.in_motion && base_cnt != '1) begin
            px_cnt = base_cnt + CNT_W'(1);
        end
        frame_done = px_take && px_x == X_LAST && px_y == Y_LAST;
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_cnt_d   = res_cnt_q;
        res_alarm_d = res_alarm_q;
        overrun_d   = overrun_q;
        abort_d     = 1'b0;

        if (px_take) begin
            state_d = ST_ACCUM;
            cnt_d   = px_cnt;
            abort_d = (state_q == ST_ACCUM) && bus.in_sof;
            if (px_x == X_LAST) begin
                x_d = '0;
                y_d = px_y + YW'(1);
            end else begin
                x_d = px_x + XW'(1);
                y_d = px_y;
            end
        end

        // Completion wins over acceptance: a result taken this cycle is replaced, not lost.
        if (frame_done) begin
            state_d     = ST_IDLE;
            x_d         = '0;
            y_d         = '0;
            cnt_d       = '0;
            res_valid_d = 1'b1;
            res_cnt_d   = px_cnt;
            res_alarm_d = (px_cnt >= bus.alarm_threshold);
            overrun_d   = overrun_q | (res_valid_q & ~bus.result_ready);
        end else if (res_valid_q && bus.result_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_cnt_q   <= '0;
            res_alarm_q <= 1'b0;
            overrun_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_cnt_q   <= res_cnt_d;
            res_alarm_q <= res_alarm_d;
            overrun_q   <= overrun_d;
            abort_q     <= abort_d;
        end
    end

    assign bus.result_valid = res_valid_q;
    assign bus.motion_count = res_cnt_q;
    assign bus.alarm        = res_alarm_q;
    assign bus.overrun      = overrun_q;
    assign bus.frame_abort  = abort_q;

`ifdef MOTION_FRAME_BBOX_EN
    logic [XW-1:0] bx_min_q, bx_min_d, bx_max_q, bx_max_d, ux_min, ux_max;
    logic [YW-1:0] by_min_q, by_min_d, by_max_q, by_max_d, uy_min, uy_max;
    logic [XW-1:0] rbx_min_q, rbx_min_d, rbx_max_q, rbx_max_d;
    logic [YW-1:0] rby_min_q, rby_min_d, rby_max_q, rby_max_d;
    logic          rb_valid_q, rb_valid_d;

    always_comb begin
        ux_min = bus.in_sof ? '0 : bx_min_q;
        ux_max = bus.in_sof ? '0 : bx_max_q;
        uy_min = bus.in_sof ? '0 : by_min_q;
        uy_max = bus.in_sof ? '0 : by_max_q;
        // The first motion pixel of a frame seeds the box; later ones widen it.
        if (bus.in_motion) begin
            if (base_cnt == '0) begin
                ux_min = px_x;
                ux_max = px_x;
                uy_min = px_y;
                uy_max = px_y;
            end else begin
                if (px_x < ux_min) ux_min = px_x;
                if (px_x > ux_max) ux_max = px_x;
                if (px_y < uy_min) uy_min = px_y;
                if (px_y > uy_max) uy_max = px_y;
            end
        end

        bx_min_d   = bx_min_q;
        bx_max_d   = bx_max_q;
        by_min_d   = by_min_q;
        by_max_d   = by_max_q;
        rbx_min_d  = rbx_min_q;
        rbx_max_d  = rbx_max_q;
        rby_min_d  = rby_min_q;
        rby_max_d  = rby_max_q;
        rb_valid_d = rb_valid_q;

        if (px_take) begin
            bx_min_d = ux_min;
            bx_max_d = ux_max;
            by_min_d = uy_min;
            by_max_d = uy_max;
        end
        if (frame_done) begin
            bx_min_d   = '0;
            bx_max_d   = '0;
            by_min_d   = '0;
            by_max_d   = '0;
            rb_valid_d = (px_cnt != '0);
            rbx_min_d  = (px_cnt != '0) ? ux_min : '0;
            rbx_max_d  = (px_cnt != '0) ? ux_max : '0;
            rby_min_d  = (px_cnt != '0) ? uy_min : '0;
            rby_max_d  = (px_cnt != '0) ? uy_max : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bx_min_q   <= '0;
            bx_max_q   <= '0;
            by_min_q   <= '0;
            by_max_q   <= '0;
            rbx_min_q  <= '0;
            rbx_max_q  <= '0;
            rby_min_q  <= '0;
            rby_max_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            bx_min_q   <= bx_min_d;
            bx_max_q   <= bx_max_d;
            by_min_q   <= by_min_d;
            by_max_q   <= by_max_d;
            rbx_min_q  <= rbx_min_d;
            rbx_max_q  <= rbx_max_d;
            rby_min_q  <= rby_min_d;
            rby_max_q  <= rby_max_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign bus.bbox_x_min = rbx_min_q;
    assign bus.bbox_x_max = rbx_max_q;
    assign bus.bbox_y_min = rby_min_q;
    assign bus.bbox_y_max = rby_max_q;
    assign bus.bbox_valid = rb_valid_q;
`else
    assign bus.bbox_x_min = '0;
    assign bus.bbox_x_max = '0;
    assign bus.bbox_y_min = '0;
    assign bus.bbox_y_max = '0;
    assign bus.bbox_valid = 1'b0;
`endif

endmodule

// File: tb/tb_motion_frame_collector.sv
// Scoreboard bench for motion_frame_collector on a 4x3 image with a 4-bit counter.
module tb_motion_frame_collector;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 4;

    typedef logic [13:0] exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    motion_frame_collector_if #(.IMG_W(W), .IMG_H(H), .CNT_W(CW)) bus ();

    motion_frame_collector #(.IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   abort_seen;

    function automatic exp_t observed();
        return {bus.motion_count, bus.alarm, bus.bbox_valid,
                bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max};
    endfunction

    function automatic logic [16:0] all_outs();
        return {bus.result_valid, bus.overrun, bus.frame_abort, observed()};
    endfunction

    function automatic exp_t model(input logic [11:0] mot, input logic [3:0] thr);
        int         c, xmn, xmx, ymn, ymx;
        logic [3:0] c4;
        logic       al, bv;
        logic [1:0] a, b, cc, d;
        c = 0; xmn = W - 1; xmx = 0; ymn = H - 1; ymx = 0;
        for (int i = 0; i < W * H; i++) begin
            if (mot[i]) begin
                c++;
                if (i % W < xmn) xmn = i % W;
                if (i % W > xmx) xmx = i % W;
                if (i / W < ymn) ymn = i / W;
                if (i / W > ymx) ymx = i / W;
            end
        end
        c4 = (c > 15) ? 4'd15 : 4'(c);
        al = (c4 >= thr);
        bv = 1'b0; a = '0; b = '0; cc = '0; d = '0;
`ifdef MOTION_FRAME_BBOX_EN
        if (c > 0) begin
            bv = 1'b1; a = 2'(xmn); b = 2'(xmx); cc = 2'(ymn); d = 2'(ymx);
        end
`endif
        return {c4, al, bv, a, b, cc, d};
    endfunction

    task automatic drive_px(input logic v, input logic sof, input logic m);
        bus.in_valid  = v;
        bus.in_sof    = sof;
        bus.in_motion = m;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [11:0] mot, input logic [3:0] thr,
                              input bit push, input int gap_max, input int npx);
        bus.alarm_threshold = thr;
        if (push) sb.push_back(model(mot, thr));
        abort_seen = 0;
        for (int i = 0; i < npx; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                drive_px(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
                if (bus.frame_abort) abort_seen++;
            end
            drive_px(1'b1, i == 0, mot[i]);
            if (bus.frame_abort) abort_seen++;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (all_outs() !== 17'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", all_outs());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < W * H; i++) drive_px(1'b1, 1'b0, 1'b1);
        drive_px(1'b0, 1'b0, 1'b0);
        drive_px(1'b0, 1'b0, 1'b0);
        total++;
        if (all_outs() !== 17'd0) begin
            bad++; $display("FAIL no_sof_ignored got=%h want=0", all_outs());
        end
    endtask

    task automatic test_single();
        exp_t e;
        bus.result_ready = 1'b1;
        send_frame(12'h482, 4'd3, 1'b1, 0, W * H);
        total++;
        if (bus.result_valid !== 1'b1) begin
            bad++; $display("FAIL single_valid got=%b want=1", bus.result_valid);
        end
        e = sb.pop_front();
        total++;
        if (observed() !== e) begin
            bad++; $display("FAIL single_result got=%h want=%h", observed(), e);
        end
        drive_px(1'b0, 1'b0, 1'b0);
        total++;
        if (bus.result_valid !== 1'b0) begin
            bad++; $display("FAIL single_drop got=%b want=0", bus.result_valid);
        end
    endtask

    task automatic test_gaps();
        exp_t e;
        bus.result_ready = 1'b1;
        for (int t = 12; t <= 13; t++) begin
            send_frame(12'hFFF, 4'(t), 1'b1, 3, W * H);
            e = sb.pop_front();
            total++;
            if (bus.result_valid !== 1'b1 || observed() !== e) begin
                bad++; $display("FAIL gaps_thr%0d got=%b/%h want=1/%h", t, bus.result_valid, observed(), e);
            end
            drive_px(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        bus.result_ready = 1'b1;
        send_frame(12'h07F, 4'd2, 1'b0, 0, 7);
        total++;
        if (bus.result_valid !== 1'b0) begin
            bad++; $display("FAIL abort_partial_valid got=%b want=0", bus.result_valid);
        end
        send_frame(12'h0A5, 4'd2, 1'b1, 0, W * H);
        total++;
        if (abort_seen !== 1) begin
            bad++; $display("FAIL abort_pulses got=%0d want=1", abort_seen);
        end
        e = sb.pop_front();
        total++;
        if (bus.result_valid !== 1'b1 || observed() !== e) begin
            bad++; $display("FAIL abort_result got=%b/%h want=1/%h", bus.result_valid, observed(), e);
        end
        drive_px(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_zero();
        exp_t e;
        bus.result_ready = 1'b1;
        send_frame(12'h000, 4'd1, 1'b1, 0, W * H);
        e = sb.pop_front();
        total++;
        if (bus.result_valid !== 1'b1 || observed() !== e) begin
            bad++; $display("FAIL zero_result got=%b/%h want=1/%h", bus.result_valid, observed(), e);
        end
        drive_px(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        exp_t       held, e;
        logic [11:0] mb;
        bus.result_ready = 1'b0;
        send_frame(12'h300, 4'd2, 1'b1, 0, W * H);
        held = sb.pop_front();
        total++;
        if (bus.result_valid !== 1'b1 || observed() !== held) begin
            bad++; $display("FAIL b2b_first got=%b/%h want=1/%h", bus.result_valid, observed(), held);
        end
        mb = 12'hC33;
        bus.alarm_threshold = 4'd7;
        sb.push_back(model(mb, 4'd7));
        for (int i = 0; i < W * H - 1; i++) begin
            drive_px(1'b1, i == 0, mb[i]);
            if (i == 5) begin
                total++;
                if (bus.result_valid !== 1'b1 || observed() !== held) begin
                    bad++; $display("FAIL b2b_hold got=%b/%h want=1/%h", bus.result_valid, observed(), held);
                end
            end
        end
        bus.result_ready = 1'b1;
        drive_px(1'b1, 1'b0, mb[W * H - 1]);
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        total++;
        if (bus.result_valid !== 1'b1 || bus.overrun !== 1'b0 || observed() !== e) begin
            bad++; $display("FAIL b2b_second got=%b/%b/%h want=1/0/%h", bus.result_valid, bus.overrun, observed(), e);
        end
        drive_px(1'b0, 1'b0, 1'b0);
        total++;
        if (bus.result_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_drop got=%b want=0", bus.result_valid);
        end
    endtask

    task automatic test_overrun();
        exp_t e;
        bus.result_ready = 1'b0;
        send_frame(12'h011, 4'd4, 1'b1, 0, W * H);
        total++;
        if (bus.result_valid !== 1'b1 || bus.overrun !== 1'b0) begin
            bad++; $display("FAIL ovr_first got=%b/%b want=1/0", bus.result_valid, bus.overrun);
        end
        send_frame(12'h01F, 4'd4, 1'b1, 0, W * H);
        void'(sb.pop_front());
        e = sb.pop_front();
        total++;
        if (bus.overrun !== 1'b1 || observed() !== e) begin
            bad++; $display("FAIL ovr_second got=%b/%h want=1/%h", bus.overrun, observed(), e);
        end
        bus.result_ready = 1'b1;
        drive_px(1'b0, 1'b0, 1'b0);
        total++;
        if (bus.result_valid !== 1'b0 || bus.overrun !== 1'b1) begin
            bad++; $display("FAIL ovr_sticky got=%b/%b want=0/1", bus.result_valid, bus.overrun);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bus.result_ready = 1'b0;
        send_frame(12'h001, 4'd1, 1'b1, 0, W * H);
        e = sb.pop_front();
        total++;
        if (bus.result_valid !== 1'b1 || observed() !== e) begin
            bad++; $display("FAIL rmid_pre got=%b/%h want=1/%h", bus.result_valid, observed(), e);
        end
        for (int i = 0; i < 5; i++) drive_px(1'b1, i == 0, 1'b1);
        #2 rst = 1'b1;
        #1;
        total++;
        if (all_outs() !== 17'd0) begin
            bad++; $display("FAIL rmid_async got=%h want=0", all_outs());
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.result_ready = 1'b1;
        send_frame(12'h842, 4'd3, 1'b1, 0, W * H);
        e = sb.pop_front();
        total++;
        if (bus.result_valid !== 1'b1 || bus.overrun !== 1'b0 || observed() !== e) begin
            bad++; $display("FAIL rmid_after got=%b/%b/%h want=1/0/%h", bus.result_valid, bus.overrun, observed(), e);
        end
        drive_px(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.in_valid        = 1'b0;
        bus.in_sof          = 1'b0;
        bus.in_motion       = 1'b0;
        bus.alarm_threshold = '0;
        bus.result_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_gaps();
        test_abort();
        test_zero();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/motion_frame_collector.md
Name: motion_frame_collector

Overview:
- Consumes the per-pixel motion_detected stream from the motion detector in raster order and reduces each frame to a summary: motion pixel count, alarm flag and optional bounding box.
- Sits downstream of the motion detector. It is the reader of its output flag, and its result goes to the frame-level control/host interface through a valid/ready handshake.
- Accumulation and result registers are separate, so the next frame can be collected while a result waits.

Parameters:
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- CNT_W, 19, motion counter width; must hold IMG_W*IMG_H

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  pixel flag valid this cycle
- in_sof  input  1  first pixel of frame; qualified by in_valid
- in_motion  input  1  motion_detected flag for this pixel
- alarm_threshold  input  CNT_W  runtime alarm level; sampled at frame completion
- result_valid  output  1  frame summary available
- result_ready  input  1  consumer accepts summary
- motion_count  output  CNT_W  motion pixels in the reported frame
- alarm  output  1  motion_count >= alarm_threshold
- overrun  output  1  sticky: a completed frame overwrote an unaccepted result
- frame_abort  output  1  one-cycle pulse: in_sof arrived mid-frame
- bbox_x_min, bbox_x_max  output  $clog2(IMG_W)  bounding box columns (see Optional Feature)
- bbox_y_min, bbox_y_max  output  $clog2(IMG_H)  bounding box rows
- bbox_valid  output  1  at least one motion pixel in the reported frame

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs are 0.
  - Counters x=0, y=0, accumulator=0.
  - FSM enters IDLE.
- FSM, IDLE:
  - Pixels are ignored until in_valid && in_sof.
  - That pixel is accumulated as (x=0, y=0) and the FSM goes to ACCUM.
- FSM, ACCUM, on each in_valid:
  - Accumulate in_motion.
  - x increments; at IMG_W-1, x wraps to 0 and y increments.
  - in_valid=0 cycles are stalls; all state holds.
- Frame completion:
  - Triggered by an accepted pixel at x=IMG_W-1 and y=IMG_H-1; that pixel is included.
  - Next cycle: result registers load, result_valid=1, and the FSM returns to IDLE.
  - Accumulators clear, ready for the next in_sof on the following cycle.
- Mid-frame in_sof:
  - In ACCUM, in_valid && in_sof discards the partial frame.
  - frame_abort pulses the next cycle.
  - Accumulation restarts with this pixel as (0,0).
  - No result is produced for the aborted frame.
- Count arithmetic:
  - Increments by 1 per motion pixel.
  - Saturates at 2^CNT_W-1 and never wraps.
- Alarm:
  - alarm = (final count >= alarm_threshold), evaluated at completion and registered with the result.
  - alarm_threshold=0 means alarm=1 for every frame.
- Result handshake:
  - result_valid stays high, with all result fields stable, until result_valid && result_ready.
  - result_valid drops the cycle after acceptance.
- Completion while result_valid=1 and result_ready=0:
  - The new frame overwrites the result.
  - result_valid stays 1.
  - overrun sets and stays set until reset.
- Completion in the same cycle as acceptance of the old result: the new result loads, result_valid stays 1, and overrun is not set.
- in_motion is don't-care when in_valid=0.

Optional Feature:
- Macro: MOTION_FRAME_BBOX_EN.
- Defined:
  - Track min/max x and y over pixels with in_motion=1; these registers are cleared by frame start.
  - Load the box into the bbox_* outputs and set bbox_valid=1 at completion if count>0.
  - If count=0, bbox_valid=0 and the coordinates are 0.
- Undefined:
  - No tracking logic is built.
  - All bbox_* outputs and bbox_valid are tied to 0.
- Count, alarm and handshake behaviour are identical either way.

Test Plan (IMG_W=4, IMG_H=3, CNT_W=4):
- Single frame, motion at (1,0),(3,1),(2,2), alarm_threshold=3, result_ready=1:
  - result_valid pulses 1 cycle after the 12th pixel with motion_count=3 and alarm=1.
  - With the macro defined: bbox x 1..3, y 0..2, bbox_valid=1.
- All-motion frame with random in_valid gaps: count=12, alarm=1 for threshold 12 and alarm=0 for threshold 13; stalls do not change the result.
- result_ready=0 for two complete frames (counts 2 then 5):
  - After the second frame, motion_count=5 and overrun=1.
  - Assert result_ready: result_valid drops next cycle; overrun stays 1.
- in_sof at pixel 7 of a frame: frame_abort pulses once; the following 12 pixels form a frame whose count includes only those pixels.
- Pixels without a preceding in_sof after reset produce no result. Reset asserted mid-frame zeroes all outputs asynchronously, and the next in_sof frame reports correctly.
- Frame with zero motion: motion_count=0, bbox_valid=0, alarm=0 with alarm_threshold=1.
